// File: rtl/wshb_rr_arbiter_if.sv
// Wishbone B4 bus bundle shared by the SDRAM masters and the SDRAM slave port.
interface wshb_if #(
  parameter int unsigned DATA_BYTES = 4
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [DATA_BYTES*8-1:0] dat_ms;
  logic [DATA_BYTES*8-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wshb_rr_arbiter.sv
// Round-robin two-master Wishbone arbiter for the SDRAM port, with a per-grant
// hold limit that only preempts the holder on a completed classic/end-of-burst beat.
module wshb_rr_arbiter #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned MAX_HOLD   = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wshb_if.slave       wshb_ifs_m0,
  wshb_if.slave       wshb_ifs_m1,
  wshb_if.master      wshb_ifm_sdram,
  output logic [1:0]  gnt,
  output logic [15:0] preempt_cnt
);

  localparam int unsigned DW      = DATA_BYTES * 8;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  preempt_d;
  logic              req0, req1;
  logic              bound0, bound1;
  logic              force0_c, force1_c;

  assign req0 = wshb_ifs_m0.cyc;
  assign req1 = wshb_ifs_m1.cyc;

  // A beat is a legal preemption point only when it completes a classic cycle or ends a burst.
  assign bound0 = (wshb_ifs_m0.cti == 3'b000) || (wshb_ifs_m0.cti == 3'b111);
  assign bound1 = (wshb_ifs_m1.cti == 3'b000) || (wshb_ifs_m1.cti == 3'b111);

  assign force0_c = (hold_q >= HOLD_LIM) && req1 && wshb_ifm_sdram.ack && bound0;
  assign force1_c = (hold_q >= HOLD_LIM) && req0 && wshb_ifm_sdram.ack && bound1;

  // State, fairness pointer and counters
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      hold_q      <= '0;
      preempt_cnt <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      preempt_cnt <= preempt_d;
    end
  end

  // Next-state: a dropped cyc is always a normal release, even if the force condition also holds
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = preempt_cnt;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (req0 && !req1) begin
          state_d = G0;
        end else if (req1 && !req0) begin
          state_d = G1;
        end else if (req0 && req1) begin
          state_d = last_q ? G0 : G1;
        end
      end
      G0: begin
        if (!req0 || force0_c) begin
          state_d = IDLE;
          last_d  = 1'b0;
          hold_d  = '0;
          if (req0 && preempt_cnt != CNT_MAX) begin
            preempt_d = preempt_cnt + CNT_W'(1);
          end
        end else if (hold_q < HOLD_LIM) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      G1: begin
        if (!req1 || force1_c) begin
          state_d = IDLE;
          last_d  = 1'b1;
          hold_d  = '0;
          if (req1 && preempt_cnt != CNT_MAX) begin
            preempt_d = preempt_cnt + CNT_W'(1);
          end
        end else if (hold_q < HOLD_LIM) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt = state_q;

  // Read data is broadcast; only the holder ever sees a handshake
  assign wshb_ifs_m0.dat_sm = wshb_ifm_sdram.dat_sm;
  assign wshb_ifs_m1.dat_sm = wshb_ifm_sdram.dat_sm;

  // Registered-grant, combinational request/response mux
  always_comb begin
    wshb_ifm_sdram.cyc    = 1'b0;
    wshb_ifm_sdram.stb    = 1'b0;
    wshb_ifm_sdram.we     = 1'b0;
    wshb_ifm_sdram.adr    = 32'(0);
    wshb_ifm_sdram.dat_ms = DW'(0);
    wshb_ifm_sdram.sel    = DATA_BYTES'(0);
    wshb_ifm_sdram.cti    = 3'b000;
    wshb_ifm_sdram.bte    = 2'b00;
    wshb_ifs_m0.ack       = 1'b0;
    wshb_ifs_m0.err       = 1'b0;
    wshb_ifs_m0.rty       = 1'b0;
    wshb_ifs_m1.ack       = 1'b0;
    wshb_ifs_m1.err       = 1'b0;
    wshb_ifs_m1.rty       = 1'b0;
    unique case (state_q)
      G0: begin
        wshb_ifm_sdram.cyc    = wshb_ifs_m0.cyc;
        wshb_ifm_sdram.stb    = wshb_ifs_m0.stb;
        wshb_ifm_sdram.we     = wshb_ifs_m0.we;
        wshb_ifm_sdram.adr    = wshb_ifs_m0.adr;
        wshb_ifm_sdram.dat_ms = wshb_ifs_m0.dat_ms;
        wshb_ifm_sdram.sel    = wshb_ifs_m0.sel;
        wshb_ifm_sdram.cti    = wshb_ifs_m0.cti;
        wshb_ifm_sdram.bte    = wshb_ifs_m0.bte;
        wshb_ifs_m0.ack       = wshb_ifm_sdram.ack;
        wshb_ifs_m0.err       = wshb_ifm_sdram.err;
        wshb_ifs_m0.rty       = wshb_ifm_sdram.rty;
      end
      G1: begin
        wshb_ifm_sdram.cyc    = wshb_ifs_m1.cyc;
        wshb_ifm_sdram.stb    = wshb_ifs_m1.stb;
        wshb_ifm_sdram.we     = wshb_ifs_m1.we;
        wshb_ifm_sdram.adr    = wshb_ifs_m1.adr;
        wshb_ifm_sdram.dat_ms = wshb_ifs_m1.dat_ms;
        wshb_ifm_sdram.sel    = wshb_ifs_m1.sel;
        wshb_ifm_sdram.cti    = wshb_ifs_m1.cti;
        wshb_ifm_sdram.bte    = wshb_ifs_m1.bte;
        wshb_ifs_m1.ack       = wshb_ifm_sdram.ack;
        wshb_ifs_m1.err       = wshb_ifm_sdram.err;
        wshb_ifs_m1.rty       = wshb_ifm_sdram.rty;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Directed bench for wshb_rr_arbiter: reset, single requester, tie-break,
// forced release, burst protection and asynchronous reset mid-grant.
module tb_wshb_rr_arbiter;

  localparam int unsigned DB       = 4;
  localparam int unsigned HOLD     = 4;
  localparam logic [31:0] DAT_XOR  = 32'h5A5A_0000;

  logic        sys_clk;
  logic        sys_rst;
  logic [1:0]  gnt;
  logic [15:0] preempt_cnt;
  logic        slv_err;
  int          checks;
  int          failures;
  int          ack0_n;
  int          ack1_n;
  int          snap;

  wshb_if #(.DATA_BYTES(DB)) m0_if ();
  wshb_if #(.DATA_BYTES(DB)) m1_if ();
  wshb_if #(.DATA_BYTES(DB)) sd_if ();

  wshb_rr_arbiter #(
    .DATA_BYTES (DB),
    .MAX_HOLD   (HOLD)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .wshb_ifs_m0    (m0_if),
    .wshb_ifs_m1    (m1_if),
    .wshb_ifm_sdram (sd_if),
    .gnt            (gnt),
    .preempt_cnt    (preempt_cnt)
  );

  // Zero-wait SDRAM model: answers every strobe in the same cycle, data derived from address
  assign sd_if.ack    = sd_if.cyc & sd_if.stb & ~slv_err;
  assign sd_if.err    = sd_if.cyc & sd_if.stb & slv_err;
  assign sd_if.rty    = 1'b0;
  assign sd_if.dat_sm = sd_if.adr ^ DAT_XOR;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (m0_if.ack) ack0_n++;
    if (m1_if.ack) ack1_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    m0_if.cyc = cyc;
    m0_if.stb = cyc;
    m0_if.adr = adr;
    m0_if.cti = cti;
  endtask

  task automatic drive_m1(input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    m1_if.cyc = cyc;
    m1_if.stb = cyc;
    m1_if.adr = adr;
    m1_if.cti = cti;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ack0_n   = 0;
    ack1_n   = 0;
    slv_err  = 1'b0;
    sys_rst  = 1'b0;
    m0_if.we = 1'b0; m0_if.dat_ms = '0; m0_if.sel = '1; m0_if.bte = 2'b00;
    m1_if.we = 1'b0; m1_if.dat_ms = '0; m1_if.sel = '1; m1_if.bte = 2'b00;
    drive_m0(1'b0, 32'h0, 3'b000);
    drive_m1(1'b0, 32'h0, 3'b000);

    // Reset then idle
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sd_cyc", 32'(sd_if.cyc), 32'h0);
    check("rst_pcnt", 32'(preempt_cnt), 32'h0);
    sys_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_sd_cyc", 32'(sd_if.cyc), 32'h0);
    end
    check("idle_pcnt", 32'(preempt_cnt), 32'h0);

    // Single requester: m1 does 8 classic reads
    snap = ack1_n;
    drive_m1(1'b1, 32'h0000_1000, 3'b000);
    tick();
    check("m1_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 8; i++) begin
      m1_if.adr = 32'h0000_1000 + 32'(4 * i);
      #1;
      check("m1_ack", 32'(m1_if.ack), 32'h1);
      check("m1_dat", m1_if.dat_sm, (32'h0000_1000 + 32'(4 * i)) ^ DAT_XOR);
      check("m1_m0_ack", 32'(m0_if.ack), 32'h0);
      tick();
    end
    drive_m1(1'b0, 32'h0, 3'b000);
    tick();
    check("m1_rel_gnt", 32'(gnt), 32'h0);
    check("m1_acks", 32'(ack1_n - snap), 32'd8);
    tick();
    check("m1_idle_gnt", 32'(gnt), 32'h0);

    // Tie-break after reset: m0 first, one idle cycle, then m1
    sys_rst = 1'b0;
    tick();
    sys_rst = 1'b1;
    drive_m0(1'b1, 32'h0000_2000, 3'b000);
    drive_m1(1'b1, 32'h0000_3000, 3'b000);
    tick();
    check("tie_gnt0", 32'(gnt), 32'h1);
    check("tie_m0_ack", 32'(m0_if.ack), 32'h1);
    check("tie_m1_ack", 32'(m1_if.ack), 32'h0);
    tick();
    drive_m0(1'b0, 32'h0, 3'b000);
    tick();
    check("tie_idle_gnt", 32'(gnt), 32'h0);
    check("tie_idle_sd_cyc", 32'(sd_if.cyc), 32'h0);
    tick();
    check("tie_gnt1", 32'(gnt), 32'h2);
    check("tie_m1_ack2", 32'(m1_if.ack), 32'h1);
    slv_err = 1'b1;
    #1;
    check("err_m1", 32'(m1_if.err), 32'h1);
    check("err_m1_ack", 32'(m1_if.ack), 32'h0);
    check("err_m0", 32'(m0_if.err), 32'h0);
    slv_err = 1'b0;
    tick();
    drive_m1(1'b0, 32'h0, 3'b000);
    tick();
    check("tie_end_gnt", 32'(gnt), 32'h0);

    // Forced release: m0 streams, m1 joins at grant cycle 2, release on 5th ack
    snap = ack0_n;
    drive_m0(1'b1, 32'h0000_4000, 3'b000);
    tick();
    check("frc_gnt0", 32'(gnt), 32'h1);
    for (int g = 0; g < 5; g++) begin
      m0_if.adr = 32'h0000_4000 + 32'(4 * g);
      if (g == 2) drive_m1(1'b1, 32'h0000_5000, 3'b000);
      #1;
      check("frc_m0_ack", 32'(m0_if.ack), 32'h1);
      check("frc_gnt_hold", 32'(gnt), 32'h1);
      tick();
    end
    m0_if.adr = 32'h0000_4014;
    #1;
    check("frc_idle_gnt", 32'(gnt), 32'h0);
    check("frc_idle_m0_ack", 32'(m0_if.ack), 32'h0);
    check("frc_pcnt", 32'(preempt_cnt), 32'h1);
    check("frc_m0_acks", 32'(ack0_n - snap), 32'd5);
    tick();
    check("frc_gnt1", 32'(gnt), 32'h2);
    check("frc_m1_ack", 32'(m1_if.ack), 32'h1);
    check("frc_m1_dat", m1_if.dat_sm, 32'h0000_5000 ^ DAT_XOR);
    check("frc_m0_wait", 32'(m0_if.ack), 32'h0);
    tick();
    drive_m1(1'b0, 32'h0, 3'b000);
    tick();
    check("frc_idle2_gnt", 32'(gnt), 32'h0);
    tick();
    check("frc_regnt0", 32'(gnt), 32'h1);
    check("frc_pend_ack", 32'(m0_if.ack), 32'h1);
    check("frc_pend_dat", m0_if.dat_sm, 32'h0000_4014 ^ DAT_XOR);
    tick();
    drive_m0(1'b0, 32'h0, 3'b000);
    tick();
    check("frc_pcnt_end", 32'(preempt_cnt), 32'h1);

    // Burst protection: 6-beat burst, hold limit reached mid-burst, release only on cti=111
    snap = ack0_n;
    drive_m0(1'b1, 32'h0000_6000, 3'b010);
    tick();
    check("bst_gnt0", 32'(gnt), 32'h1);
    for (int b = 0; b < 6; b++) begin
      m0_if.adr = 32'h0000_6000 + 32'(4 * b);
      m0_if.cti = (b == 5) ? 3'b111 : 3'b010;
      if (b == 0) drive_m1(1'b1, 32'h0000_7000, 3'b000);
      #1;
      check("bst_gnt_hold", 32'(gnt), 32'h1);
      check("bst_m0_ack", 32'(m0_if.ack), 32'h1);
      tick();
    end
    drive_m0(1'b0, 32'h0, 3'b000);
    #1;
    check("bst_rel_gnt", 32'(gnt), 32'h0);
    check("bst_pcnt", 32'(preempt_cnt), 32'h2);
    check("bst_m0_acks", 32'(ack0_n - snap), 32'd6);
    tick();
    check("bst_gnt1", 32'(gnt), 32'h2);
    check("bst_m1_ack", 32'(m1_if.ack), 32'h1);
    tick();
    drive_m1(1'b0, 32'h0, 3'b000);
    tick();
    check("bst_end_gnt", 32'(gnt), 32'h0);

    // Asynchronous reset in the middle of a G1 cycle
    drive_m1(1'b1, 32'h0000_8000, 3'b010);
    tick();
    check("ar_gnt1", 32'(gnt), 32'h2);
    check("ar_sd_cyc", 32'(sd_if.cyc), 32'h1);
    #3;
    sys_rst = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_sd_cyc0", 32'(sd_if.cyc), 32'h0);
    check("ar_m1_ack", 32'(m1_if.ack), 32'h0);
    check("ar_pcnt", 32'(preempt_cnt), 32'h0);
    drive_m1(1'b0, 32'h0, 3'b000);
    tick();
    tick();
    sys_rst = 1'b1;
    drive_m0(1'b1, 32'h0000_9000, 3'b000);
    drive_m1(1'b1, 32'h0000_A000, 3'b000);
    tick();
    check("ar_tie_gnt", 32'(gnt), 32'h1);
    drive_m0(1'b0, 32'h0, 3'b000);
    drive_m1(1'b0, 32'h0, 3'b000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
